// File: rtl/corelet_pkg.sv
// Shared definitions for the corelet tile sequencer: instruction-word bit
// positions and the sequencer state encoding.
package corelet_pkg;

  localparam int INST_W   = 35;
  localparam int LOAD     = 0;
  localparam int EXEC     = 1;
  localparam int L0_WR    = 2;
  localparam int L0_RD    = 3;
  localparam int OFIFO_RD = 6;
  localparam int ACC      = 33;
  localparam int MODE     = 34;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_L0,
    S_W_KLD,
    S_W_GAP,
    S_X_L0,
    S_X_EXE,
    S_DRAIN,
    S_ACC,
    S_DONE
  } state_t;

endpackage

// File: rtl/seq_rd_strobe.sv
// SRAM read helper: address = base + running index while enabled, plus the
// matching data-valid strobe one cycle behind each read.
module seq_rd_strobe #(
  parameter int addr_bw = 11,
  parameter int idx_bw  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [addr_bw-1:0] base,
  output logic [addr_bw-1:0] addr,
  output logic               strb
);

  logic [idx_bw-1:0] idx_q;

  // The index restarts whenever reads pause, so every burst begins at base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      strb  <= 1'b0;
    end else begin
      idx_q <= en ? idx_q + idx_bw'(1) : '0;
      strb  <= en;
    end
  end

  assign addr = base + addr_bw'(idx_q);

endmodule

// File: rtl/corelet_seq.sv
// Corelet tile sequencer: weight load, activation execute, psum drain and
// optional SFP accumulate, driving the corelet instruction word and SRAM pins.
//
// state   | meaning
// IDLE    | wait for start, latch tile configuration
// W_L0    | read row weight vectors from xmem into L0
// W_KLD   | shift weights from L0 into the MAC array
// W_GAP   | let weights settle through the array
// X_L0    | read T activation vectors from xmem into L0
// X_EXE   | stream activations through the array
// DRAIN   | move output FIFO rows into pmem, stalling on empty FIFO
// ACC     | replay psums from pmem through the SFP accumulators
// DONE    | one-cycle completion pulse
module corelet_seq
  import corelet_pkg::*;
#(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int xaddr_bw = 11,
  parameter int paddr_bw = 11,
  parameter int cnt_bw   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode_2b,
  input  logic                acc_en,
  input  logic [cnt_bw-1:0]   num_act,
  input  logic [xaddr_bw-1:0] w_base,
  input  logic [xaddr_bw-1:0] x_base,
  input  logic [paddr_bw-1:0] p_base,
  input  logic                ofifo_valid,
  output logic [INST_W-1:0]   inst,
  output logic                xmem_cen,
  output logic [xaddr_bw-1:0] xmem_addr,
  output logic                pmem_cen,
  output logic                pmem_wen,
  output logic [paddr_bw-1:0] pmem_addr,
  output logic                busy,
  output logic                done
);

  localparam int TW = cnt_bw + 1;
  localparam logic [TW-1:0] ROW_T  = TW'(row);
  localparam logic [TW-1:0] COL_T1 = TW'(col - 1);
  localparam logic [TW-1:0] GAP_T1 = TW'(row + col - 1);

  state_t              state_q, state_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                mode_q, acc_q;
  logic [cnt_bw-1:0]   num_q;
  logic [xaddr_bw-1:0] w_base_q, x_base_q;
  logic [paddr_bw-1:0] p_base_q;

  logic                tc, x_en, p_en, wr, x_strb, p_strb;
  logic [xaddr_bw-1:0] x_base_sel, x_addr;
  logic [paddr_bw-1:0] p_addr;
  logic [cnt_bw-1:0]   dr_idx;
  logic [TW-1:0]       t_ext;

  logic [INST_W-1:0]   inst_d;
  logic                xmem_cen_d, pmem_cen_d, pmem_wen_d, busy_d, done_d;
  logic [xaddr_bw-1:0] xmem_addr_d;
  logic [paddr_bw-1:0] pmem_addr_d;

  assign tc         = (tmr_q == '0);
  assign t_ext      = {1'b0, num_q};
  assign x_en       = ((state_q == S_W_L0) || (state_q == S_X_L0)) && !tc;
  assign p_en       = (state_q == S_ACC) && !tc;
  assign wr         = (state_q == S_DRAIN) && ofifo_valid;
  assign x_base_sel = (state_q == S_W_L0) ? w_base_q : x_base_q;
  // DRAIN counts rows remaining, so the write index is T minus that.
  assign dr_idx     = num_q - tmr_q[cnt_bw-1:0];

  seq_rd_strobe #(.addr_bw(xaddr_bw), .idx_bw(cnt_bw)) u_xrd (
    .clk   (clk),
    .rst_n (reset),
    .en    (x_en),
    .base  (x_base_sel),
    .addr  (x_addr),
    .strb  (x_strb)
  );

  seq_rd_strobe #(.addr_bw(paddr_bw), .idx_bw(cnt_bw)) u_prd (
    .clk   (clk),
    .rst_n (reset),
    .en    (p_en),
    .base  (p_base_q),
    .addr  (p_addr),
    .strb  (p_strb)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    if (!tc) tmr_d = tmr_q - TW'(1);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_act == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_W_L0;
            tmr_d   = ROW_T;
          end
        end
      end
      S_W_L0:  if (tc) begin state_d = S_W_KLD; tmr_d = COL_T1; end
      S_W_KLD: if (tc) begin state_d = S_W_GAP; tmr_d = GAP_T1; end
      S_W_GAP: if (tc) begin state_d = S_X_L0;  tmr_d = t_ext; end
      S_X_L0:  if (tc) begin state_d = S_X_EXE; tmr_d = t_ext - TW'(1); end
      S_X_EXE: if (tc) begin state_d = S_DRAIN; tmr_d = t_ext; end
      S_DRAIN: begin
        tmr_d = tmr_q;
        if (ofifo_valid) begin
          tmr_d = tmr_q - TW'(1);
          if (tmr_q == TW'(1)) begin
            state_d = acc_q ? S_ACC : S_DONE;
            tmr_d   = acc_q ? t_ext : '0;
          end
        end
      end
      S_ACC:   if (tc) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase

    inst_d           = '0;
    inst_d[MODE]     = mode_q && (state_q != S_IDLE) && (state_q != S_DONE);
    inst_d[LOAD]     = (state_q == S_W_KLD);
    inst_d[L0_RD]    = (state_q == S_W_KLD) || (state_q == S_X_EXE);
    inst_d[EXEC]     = (state_q == S_X_EXE);
    inst_d[L0_WR]    = x_strb;
    inst_d[OFIFO_RD] = wr;
    inst_d[ACC]      = p_strb;

    xmem_cen_d  = !x_en;
    xmem_addr_d = x_en ? x_addr : '0;
    pmem_cen_d  = !(wr || p_en);
    pmem_wen_d  = !wr;
    pmem_addr_d = '0;
    if (wr)        pmem_addr_d = p_base_q + paddr_bw'(dr_idx);
    else if (p_en) pmem_addr_d = p_addr;
    busy_d = (state_q != S_IDLE);
    done_d = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      mode_q    <= 1'b0;
      acc_q     <= 1'b0;
      num_q     <= '0;
      w_base_q  <= '0;
      x_base_q  <= '0;
      p_base_q  <= '0;
      inst      <= '0;
      xmem_cen  <= 1'b1;
      xmem_addr <= '0;
      pmem_cen  <= 1'b1;
      pmem_wen  <= 1'b1;
      pmem_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      if ((state_q == S_IDLE) && start) begin
        mode_q   <= mode_2b;
        acc_q    <= acc_en;
        num_q    <= num_act;
        w_base_q <= w_base;
        x_base_q <= x_base;
        p_base_q <= p_base;
      end
      inst      <= inst_d;
      xmem_cen  <= xmem_cen_d;
      xmem_addr <= xmem_addr_d;
      pmem_cen  <= pmem_cen_d;
      pmem_wen  <= pmem_wen_d;
      pmem_addr <= pmem_addr_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_corelet_seq.sv
// Bench for corelet_seq: each tile's expected output trace is laid out phase
// by phase from the tile rules, then compared cycle by cycle.
module tb_corelet_seq;

  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int XBW  = 11;
  localparam int PBW  = 11;
  localparam int CBW  = 8;
  localparam int NMAX = 512;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           mode_2b = 1'b0;
  logic           acc_en = 1'b0;
  logic [CBW-1:0] num_act = '0;
  logic [XBW-1:0] w_base = '0;
  logic [XBW-1:0] x_base = '0;
  logic [PBW-1:0] p_base = '0;
  logic           ofifo_valid = 1'b0;
  logic [34:0]    inst;
  logic           xmem_cen;
  logic [XBW-1:0] xmem_addr;
  logic           pmem_cen;
  logic           pmem_wen;
  logic [PBW-1:0] pmem_addr;
  logic           busy;
  logic           done;

  int n_cmp = 0;
  int n_bad = 0;

  // expected trace, indexed by cycles since the tile started
  int             L;
  logic [34:0]    e_inst [NMAX];
  logic [XBW-1:0] e_xa   [NMAX];
  logic [PBW-1:0] e_pa   [NMAX];
  bit             e_xen  [NMAX];
  bit             e_pen  [NMAX];
  bit             e_pwr  [NMAX];
  bit             e_done [NMAX];
  bit             vv     [NMAX];

  always #5 clk = ~clk;

  corelet_seq #(.row(ROW), .col(COL), .xaddr_bw(XBW), .paddr_bw(PBW), .cnt_bw(CBW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode_2b     (mode_2b),
    .acc_en      (acc_en),
    .num_act     (num_act),
    .w_base      (w_base),
    .x_base      (x_base),
    .p_base      (p_base),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .xmem_cen    (xmem_cen),
    .xmem_addr   (xmem_addr),
    .pmem_cen    (pmem_cen),
    .pmem_wen    (pmem_wen),
    .pmem_addr   (pmem_addr),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs_vec();
    return {2'b00, inst, xmem_cen, xmem_cen ? {XBW{1'b0}} : xmem_addr,
            pmem_cen, pmem_wen, pmem_cen ? {PBW{1'b0}} : pmem_addr, busy, done};
  endfunction

  function automatic logic [63:0] idle_vec();
    return {2'b00, 35'd0, 1'b1, {XBW{1'b0}}, 1'b1, 1'b1, {PBW{1'b0}}, 1'b0, 1'b0};
  endfunction

  function automatic logic [63:0] exp_at(input int s);
    if (s < 0 || s >= L) return idle_vec();
    return {2'b00, e_inst[s], ~e_xen[s], e_xen[s] ? e_xa[s] : {XBW{1'b0}},
            ~e_pen[s], ~e_pwr[s], e_pen[s] ? e_pa[s] : {PBW{1'b0}}, 1'b1, e_done[s]};
  endfunction

  task automatic build(input bit md, input bit ac, input int t,
                       input int wb, input int xb, input int pb);
    int s;
    int r;
    logic [34:0] mb;
    s = 0;
    mb = '0;
    mb[34] = md;
    for (int i = 0; i < NMAX; i++) begin
      e_inst[i] = '0; e_xa[i] = '0; e_pa[i] = '0;
      e_xen[i] = 0; e_pen[i] = 0; e_pwr[i] = 0; e_done[i] = 0;
    end
    if (t > 0) begin
      for (int k = 0; k <= ROW; k++) begin
        e_inst[s] = mb; e_inst[s][2] = (k >= 1);
        e_xen[s] = (k < ROW); e_xa[s] = XBW'(wb + k); s++;
      end
      for (int k = 0; k < COL; k++) begin e_inst[s] = mb | 35'd9; s++; end
      for (int k = 0; k < ROW + COL; k++) begin e_inst[s] = mb; s++; end
      for (int j = 0; j <= t; j++) begin
        e_inst[s] = mb; e_inst[s][2] = (j >= 1);
        e_xen[s] = (j < t); e_xa[s] = XBW'(xb + j); s++;
      end
      for (int j = 0; j < t; j++) begin e_inst[s] = mb | 35'd10; s++; end
      r = 0;
      while (r < t && s < NMAX - 64) begin
        e_inst[s] = mb;
        if (vv[s]) begin
          e_inst[s][6] = 1'b1; e_pen[s] = 1; e_pwr[s] = 1; e_pa[s] = PBW'(pb + r); r++;
        end
        s++;
      end
      if (ac) begin
        for (int j = 0; j <= t; j++) begin
          e_inst[s] = mb; e_inst[s][33] = (j >= 1);
          e_pen[s] = (j < t); e_pa[s] = PBW'(pb + j); s++;
        end
      end
    end
    e_done[s] = 1;
    s++;
    L = s;
  endtask

  // vmode: 0 random ofifo_valid, 1 held high in DRAIN, 2 pattern 1,0,0,1,1 at DRAIN entry.
  // xtra_s: cycle at which a second start is pulsed (-1 none).
  // abort_s: cycle after which reset is asserted mid-tile (-1 none).
  task automatic run_tile(input string tag, input bit md, input bit ac, input int t,
                          input int wb, input int xb, input int pb,
                          input int vmode, input int xtra_s, input int abort_s);
    int sd;
    bit pat [5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    sd = 2 * ROW + 2 * COL + 2 * t + 2;
    for (int i = 0; i < NMAX; i++) vv[i] = ($urandom_range(0, 3) != 0);
    if (vmode == 1) for (int i = 0; i < t; i++) vv[sd + i] = 1'b1;
    if (vmode == 2) for (int i = 0; i < 5; i++) vv[sd + i] = pat[i];
    build(md, ac, t, wb, xb, pb);
    for (int n = 0; n <= L + 2; n++) begin
      @(posedge clk);
      #1;
      if (n >= 1) chk($sformatf("%s_c%0d", tag, n - 2), obs_vec(), exp_at(n - 2));
      start = (n == 0) || (xtra_s >= 0 && n == xtra_s + 1);
      if (n == 0) begin
        mode_2b = md; acc_en = ac; num_act = CBW'(t);
        w_base = XBW'(wb); x_base = XBW'(xb); p_base = PBW'(pb);
      end else if (xtra_s >= 0 && n == xtra_s + 1) begin
        mode_2b = ~md; acc_en = ~ac; num_act = CBW'($urandom_range(1, 255));
        w_base = XBW'($urandom); x_base = XBW'($urandom); p_base = PBW'($urandom);
      end
      ofifo_valid = (n >= 1) ? vv[n - 1] : 1'b0;
      if (abort_s >= 0 && n == abort_s + 2) begin
        #2 reset = 1'b0;
        #1 chk({tag, "_async_reset"}, obs_vec(), idle_vec());
        start = 1'b0;
        ofifo_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 chk({tag, "_reset_hold"}, obs_vec(), idle_vec());
        reset = 1'b1;
        return;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 chk("reset_idle", obs_vec(), idle_vec());
    reset = 1'b1;

    run_tile("t1_basic", 1'b0, 1'b0, 4, 100, 200, 300, 1, -1, -1);
    run_tile("t2_acc_mode", 1'b1, 1'b1, 3, 2000, 40, 700, 0, -1, -1);
    run_tile("t3_stall", 1'b0, 1'b0, 3, 5, 9, 1500, 2, -1, -1);
    run_tile("t4_zero", 1'b1, 1'b1, 0, 11, 22, 33, 0, -1, -1);
    run_tile("t5_abort", 1'b1, 1'b0, 6, 60, 70, 80, 0, -1,
             2 * ROW + 2 * COL + 6 + 2 + 3);
    run_tile("t5_rerun", 1'b0, 1'b1, 5, 61, 71, 81, 0, -1, -1);
    run_tile("t6_wrap", 1'b0, 1'b1, 4, 2044, 2046, 2046, 1, 20, -1);
    for (int i = 0; i < 8; i++) begin
      run_tile($sformatf("rnd%0d", i), 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))),
               int'($urandom_range(1, 12)), int'($urandom_range(0, 2047)),
               int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 0, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

endmodule
